accel_msg_reassembler: RTL
==========================

// Module: accel_msg_reassembler
// PURPOSE
//  Input stage in front of a custom Tinsel accelerator: consumes the NoC flit stream and
//  reassembles multi-flit messages into one wide message word plus length. Idle-detection
//  tokens pass as single-flit messages. The downstream accelerator sees whole messages only.
// PARAMETERS
//  MAX_FLITS   4   max flits per message (Tinsel max message size); >=1
//  LEN_W       $clog2(MAX_FLITS+1)   width of msg_len (derived, not overridden)
// PORTS
//  clk        in   1                        clock; all state updates on negedge clk
//  rst_n      in   1                        reset
//  in_data    in   $bits(Flit)              incoming flit
//  in_valid   in   1                        in_data valid
//  in_ready   out  1                        flit accepted when in_valid && in_ready
//  msg_dest   out  $bits(NetAddr)           dest field of first flit of message
//  msg_data   out  MAX_FLITS*TinselBitsPerFlit  payloads; flit i at [i*BPF +: BPF]
//  msg_len    out  LEN_W                    number of flits stored (1..MAX_FLITS)
//  msg_idle   out  1                        message is an idle token
//  msg_trunc  out  1                        message exceeded MAX_FLITS, tail dropped
//  msg_valid  out  1                        message valid
//  msg_ready  in   1                        message consumed when msg_valid && msg_ready
//  err_proto  out  1                        sticky: idle token seen mid-message
// BEHAVIOUR
//  - Reset: rst_n, synchronous, active-low. Outputs after reset: in_ready=1, msg_valid=0,
//    msg_len=0, msg_idle=0, msg_trunc=0, err_proto=0; msg_data/msg_dest don't-care.
//  - States: COLLECT, DISCARD, FULL. in_ready = (state != FULL), registered-state only.
//  - COLLECT, flit accepted, not idle: payload to slot cnt, cnt++; first flit (cnt=0)
//    latches dest. notFinalFlit=0 -> FULL, msg_len=cnt+1. notFinalFlit=1 and
//    cnt+1==MAX_FLITS -> DISCARD, msg_trunc set.
//  - COLLECT, idle token, cnt=0: slot0=payload, msg_idle=1, msg_len=1 -> FULL.
//    Idle token with cnt>0: flit dropped, err_proto set, collection continues.
//  - DISCARD: flits accepted and dropped; flit with notFinalFlit=0 -> FULL with stored
//    MAX_FLITS flits, msg_len=MAX_FLITS, msg_trunc=1. Idle tokens in DISCARD: err_proto.
//  - FULL: msg_valid=1; outputs stable until msg_ready. On handshake -> COLLECT, cnt=0,
//    msg_idle/msg_trunc cleared. No flit accepted while FULL.
//  - Latency: final flit accepted at edge N -> msg_valid high after edge N. n-flit message
//    occupies n+1 cycles min (n flits + 1 handoff cycle).
//  - Unused slots (index >= msg_len) hold stale data; consumers use msg_len.
//  - Reset mid-message discards partial message; err_proto clears only on reset.
// CONFIGURATION
//  ACCEL_REASM_STATS_EN defined: extra outputs stat_msgs [31:0] (messages handed off,
//   idle included) and stat_drops [15:0] (flits dropped: truncation + mid-message idle);
//   both saturate at all-ones, reset to 0.
//  Undefined: those ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Shared package accel_pkg: NetAddr, Flit typedefs (from config.v widths), BPF constant,
//    state enum.
//  - Single module, no sub-modules; payload store is MAX_FLITS x BPF register array.
// TESTING
//  - Single flit dest=0x12, final, msg_ready=1 -> msg_len=1, msg_dest=0x12, valid 1 cycle.
//  - 3 flits payloads A,B,C, msg_ready=0 for 5 cycles -> msg_len=3, data {C,B,A} held,
//    in_ready=0 throughout, then released on msg_ready.
//  - 6 flits, MAX_FLITS=4 -> msg_len=4, flits 1-4 kept, msg_trunc=1, stat_drops=2.
//  - Idle token alone -> msg_idle=1, msg_len=1; idle after 1st of 2 flits -> err_proto=1,
//    2-flit message delivered intact.
//  - rst_n=0 after 2 of 3 flits -> msg_valid=0, next 1-flit message delivers msg_len=1.
//  - Back-to-back 1-flit messages, in_valid and msg_ready always 1 -> one message per 2 cycles.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared types for the Tinsel accelerator input stage: network address, flit layout
// and the reassembler state encoding. Field widths mirror the Tinsel config widths.
package accel_pkg;

   localparam int TINSEL_BITS_PER_FLIT = 32;
   localparam int BPF                  = TINSEL_BITS_PER_FLIT;
   localparam int NET_ADDR_W           = 8;

   typedef logic [NET_ADDR_W-1:0] NetAddr;

   typedef struct packed {
      NetAddr           dest;
      logic             not_final_flit;
      logic             is_idle_token;
      logic [BPF-1:0]   payload;
   } Flit;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      DISCARD = 2'd1,
      FULL    = 2'd2
   } reasm_state_e;

endpackage

// File: rtl/accel_msg_reassembler_if.sv
// Flit input stream and whole-message output stream of the reassembler.
// Optional statistics outputs exist only when ACCEL_REASM_STATS_EN is defined.
interface accel_msg_reassembler_if
   import accel_pkg::*;
#(
   parameter int MAX_FLITS = 4
);
   localparam int LEN_W = $clog2(MAX_FLITS + 1);

   Flit                        in_data;
   logic                       in_valid;
   logic                       in_ready;
   NetAddr                     msg_dest;
   logic [MAX_FLITS*BPF-1:0]   msg_data;
   logic [LEN_W-1:0]           msg_len;
   logic                       msg_idle;
   logic                       msg_trunc;
   logic                       msg_valid;
   logic                       msg_ready;
   logic                       err_proto;
`ifdef ACCEL_REASM_STATS_EN
   logic [31:0]                stat_msgs;
   logic [15:0]                stat_drops;
`endif

   // Reassembler side: consumes flits, produces messages.
   modport slave (
      input  in_data, in_valid, msg_ready,
      output in_ready, msg_dest, msg_data, msg_len, msg_idle, msg_trunc, msg_valid, err_proto
`ifdef ACCEL_REASM_STATS_EN
      , output stat_msgs, stat_drops
`endif
   );

   modport master (
      output in_data, in_valid, msg_ready,
      input  in_ready, msg_dest, msg_data, msg_len, msg_idle, msg_trunc, msg_valid, err_proto
`ifdef ACCEL_REASM_STATS_EN
      , input stat_msgs, stat_drops
`endif
   );

endinterface

// File: rtl/accel_msg_reassembler.sv
// Reassembles NoC flits into whole messages (payload word + length) for the accelerator.
// Define ACCEL_REASM_STATS_EN to add saturating message/drop counters.
module accel_msg_reassembler
   import accel_pkg::*;
#(
   parameter int MAX_FLITS = 4
)(
   input  logic                      clk,
   input  logic                      rst_n,
   accel_msg_reassembler_if.slave    bus
);
   localparam int               LEN_W   = $clog2(MAX_FLITS + 1);
   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FLITS);
   localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

   reasm_state_e      state_r, state_s;
   logic [LEN_W-1:0]  cnt_r, len_r, len_s;
   logic [BPF-1:0]    slot_r [MAX_FLITS];
   NetAddr            dest_r;
   logic              idle_r, trunc_r, err_r;
   logic              store_s, set_len_s, set_idle_s, set_trunc_s, err_s, drop_s, release_s;
   logic              accept_s;
   Flit               flit_s;

   assign flit_s   = bus.in_data;
   assign accept_s = bus.in_valid && (state_r != FULL);

   // Next-state and datapath control decode.
   always_comb begin
      state_s     = state_r;
      len_s       = len_r;
      store_s     = 1'b0;
      set_len_s   = 1'b0;
      set_idle_s  = 1'b0;
      set_trunc_s = 1'b0;
      err_s       = 1'b0;
      drop_s      = 1'b0;
      release_s   = 1'b0;
      case (state_r)
         COLLECT: begin
            if (accept_s && flit_s.is_idle_token) begin
               if (cnt_r == '0) begin
                  store_s    = 1'b1;
                  set_len_s  = 1'b1;
                  len_s      = ONE;
                  set_idle_s = 1'b1;
                  state_s    = FULL;
               end else begin
                  drop_s = 1'b1;
                  err_s  = 1'b1;
               end
            end else if (accept_s) begin
               store_s = 1'b1;
               if (!flit_s.not_final_flit) begin
                  set_len_s = 1'b1;
                  len_s     = cnt_r + ONE;
                  state_s   = FULL;
               end else if ((cnt_r + ONE) == MAX_LEN) begin
                  set_trunc_s = 1'b1;
                  state_s     = DISCARD;
               end else begin
                  state_s = COLLECT;
               end
            end else begin
               state_s = COLLECT;
            end
         end
         DISCARD: begin
            if (accept_s) begin
               drop_s = 1'b1;
               if (flit_s.is_idle_token) begin
                  err_s = 1'b1;
               end else if (!flit_s.not_final_flit) begin
                  set_len_s = 1'b1;
                  len_s     = MAX_LEN;
                  state_s   = FULL;
               end else begin
                  state_s = DISCARD;
               end
            end else begin
               state_s = DISCARD;
            end
         end
         FULL: begin
            if (bus.msg_ready) begin
               release_s = 1'b1;
               state_s   = COLLECT;
            end else begin
               state_s = FULL;
            end
         end
         default: state_s = COLLECT;
      endcase
   end

   // State register; the whole block updates on the falling edge.
   always_ff @(negedge clk) begin
      if (!rst_n) state_r <= COLLECT;
      else        state_r <= state_s;
   end

   // Control and status registers.
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         cnt_r   <= '0;
         len_r   <= '0;
         idle_r  <= 1'b0;
         trunc_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         if (release_s) begin
            cnt_r   <= '0;
            idle_r  <= 1'b0;
            trunc_r <= 1'b0;
         end else begin
            if (store_s)     cnt_r   <= cnt_r + ONE;
            if (set_idle_s)  idle_r  <= 1'b1;
            if (set_trunc_s) trunc_r <= 1'b1;
         end
         if (set_len_s) len_r <= len_s;
         if (err_s)     err_r <= 1'b1;
      end
   end

   // Payload slots and destination carry no reset: consumers qualify with msg_valid/msg_len.
   always_ff @(negedge clk) begin
      if (store_s && (cnt_r == '0)) dest_r <= flit_s.dest;
      for (int i = 0; i < MAX_FLITS; i++) begin
         if (store_s && (cnt_r == LEN_W'(i))) slot_r[i] <= flit_s.payload;
      end
   end

   for (genvar g = 0; g < MAX_FLITS; g++) begin : g_data
      assign bus.msg_data[g*BPF +: BPF] = slot_r[g];
   end

   assign bus.in_ready  = (state_r != FULL);
   assign bus.msg_valid = (state_r == FULL);
   assign bus.msg_dest  = dest_r;
   assign bus.msg_len   = len_r;
   assign bus.msg_idle  = idle_r;
   assign bus.msg_trunc = trunc_r;
   assign bus.err_proto = err_r;

`ifdef ACCEL_REASM_STATS_EN
   logic [31:0] stat_msgs_r;
   logic [15:0] stat_drops_r;

   // Saturating counters of handed-off messages and dropped flits.
   always_ff @(negedge clk) begin
      if (!rst_n) begin
         stat_msgs_r  <= 32'd0;
         stat_drops_r <= 16'd0;
      end else begin
         if (release_s && (stat_msgs_r != 32'hFFFF_FFFF)) stat_msgs_r  <= stat_msgs_r + 32'd1;
         if (drop_s && (stat_drops_r != 16'hFFFF))        stat_drops_r <= stat_drops_r + 16'd1;
      end
   end

   assign bus.stat_msgs  = stat_msgs_r;
   assign bus.stat_drops = stat_drops_r;
`endif

endmodule
